// File: rtl/mul_pkg.sv
// Shared types and constants for the M-extension multiply controller.
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam int unsigned MUL_ITERS = 32;

    // Operand A is signed for MULH and MULHSU.
    function automatic logic op_signed_a(input logic [1:0] op);
        return (op == F3_MULH[1:0]) || (op == F3_MULHSU[1:0]);
    endfunction

    // Operand B is signed only for MULH.
    function automatic logic op_signed_b(input logic [1:0] op);
        return (op == F3_MULH[1:0]);
    endfunction

endpackage

// File: rtl/mul_if.sv
// Request/response bundle between the pipeline and the multiply controller.
interface mul_if;

    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1_val, rs2_val, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, flush,
        output busy, stall, done, result
    );

endinterface

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: magnitude conversion at load, one partial
// product per step, sign restored on the 64-bit product output.
module mul_shift_add
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic        neg;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Magnitudes of the incoming operands according to the op's signedness.
    always_comb begin
        a_neg = op_signed_a(op) & a[31];
        b_neg = op_signed_b(op) & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
    end

    // Load operands, then accumulate one multiplier bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            mcand  <= {32'b0, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= a_neg ^ b_neg;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign product = neg ? (~acc + 64'd1) : acc;

endmodule

// File: rtl/mul_ctrl.sv
// Multi-cycle M-extension multiply controller: IDLE/RUN/DONE FSM, iteration
// counter and pipeline handshake around the mul_shift_add datapath.
// Optional feature: define MUL_EARLY_OUT_EN to finish zero-operand multiplies
// after a single RUN cycle with result 0.
module mul_ctrl
    import mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    mul_if.slave bus
);

    localparam logic [4:0] LAST_CNT = 5'(MUL_ITERS - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic        last_q;
    logic [1:0]  op_q;
    logic        done_q;
    logic [31:0] result_q;

    logic        accept;
    logic        load;
    logic        step;
    logic        zero_ops;
    logic [63:0] product;

    assign accept = bus.start & ~bus.funct3[2] & ~bus.flush;
    assign load   = accept & ((state == S_IDLE) || (state == S_DONE));
    assign step   = (state == S_RUN) & ~bus.flush & ~last_q;

`ifdef MUL_EARLY_OUT_EN
    assign zero_ops = (bus.rs1_val == '0) || (bus.rs2_val == '0);
`else
    assign zero_ops = 1'b0;
`endif

    mul_shift_add u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .op      (bus.funct3[1:0]),
        .a       (bus.rs1_val),
        .b       (bus.rs2_val),
        .product (product)
    );

    // FSM, iteration counter and registered done/result.
    // The counter wraps as the 32nd iteration retires; last_q then gives one
    // RUN cycle for the sign fix-up before the result is captured. An early-out
    // sets last_q at accept so the datapath's cleared accumulator is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last_q   <= 1'b0;
            op_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (load) begin
                        state  <= S_RUN;
                        op_q   <= bus.funct3[1:0];
                        cnt    <= '0;
                        last_q <= zero_ops;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        state  <= S_IDLE;
                        cnt    <= '0;
                        last_q <= 1'b0;
                    end else if (last_q) begin
                        state    <= S_DONE;
                        last_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= (op_q == F3_MUL[1:0]) ? product[31:0] : product[63:32];
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == LAST_CNT) begin
                            last_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.stall  = ((state == S_IDLE) & accept) | (state == S_RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl: stimulus pushes expected result and due
// cycle, a negedge monitor pops on every done pulse.
module tb_mul_ctrl;
    import mul_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_fail;

    mul_if bus ();

    mul_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } sb_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_t  sbq[$];
    sb_t  mon_e;
    vec_t vt[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
        if (a == 32'd0 || b == 32'd0) return 2;
`endif
        if (a == 32'hDEAD_BEEF && b == 32'hDEAD_BEEF) return 0;
        return 34;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_done: done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_result"}, bus.result, mon_e.res);
                chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    // Caller is at a negedge; drives start for one edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push, input string name);
        sb_t e;
        bus.start   = 1'b1;
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        if (push) begin
            e.res  = exp;
            e.due  = cyc + lat(a, b);
            e.name = name;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        chk({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.flush = 1'b0;

        vt[0] = '{F3_MUL,    32'd7,          32'd6,          32'h0000_002A, "mul_7x6"};
        vt[1] = '{F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, "mul_m1"};
        vt[2] = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, "mulh_m1"};
        vt[3] = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, "mulhu_max"};
        vt[4] = '{F3_MULHSU, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF, "mulhsu_m2x3"};
        vt[5] = '{F3_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, "mulh_min"};
        vt[6] = '{F3_MULHSU, 32'd3,          32'h8000_0000,  32'h0000_0001, "mulhsu_3xb31"};
        vt[7] = '{F3_MULH,   32'd3,          32'h8000_0000,  32'hFFFF_FFFE, "mulh_3xmin"};
        vt[8] = '{F3_MUL,    32'd0,          32'd5,          32'h0000_0000, "mul_0x5"};

        // Reset state
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7x6 with stall/busy observation through RUN
        issue(F3_MUL, 32'd7, 32'd6, 32'h2A, 1'b1, "stall_7x6");
        chk("run_stall_first", 32'(bus.stall), 32'd1);
        repeat (30) @(negedge clk);
        chk("run_stall_late", 32'(bus.stall), 32'd1);
        chk("run_busy_late", 32'(bus.busy), 32'd1);
        wait_idle("stall_7x6");
        chk("result_held", bus.result, 32'h2A);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            issue(vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, 1'b1, vt[i].name);
            wait_idle(vt[i].name);
        end

        // Flush at T+10, restart at T+12
        issue(F3_MUL, 32'd7, 32'd6, 32'h2A, 1'b0, "flushed");
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "after_flush");
        wait_idle("after_flush");

        // Simultaneous flush and start is ignored
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.funct3 = F3_MUL;
        bus.rs1_val = 32'd9;
        bus.rs2_val = 32'd9;
        #1;
        chk("flush_start_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_busy", 32'(bus.busy), 32'd0);

        // funct3=100 start is ignored
        bus.start = 1'b1;
        bus.funct3 = 3'b100;
        #1;
        chk("div_op_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("div_op_busy", 32'(bus.busy), 32'd0);

        // Back-to-back start in DONE; start in RUN ignored
        issue(F3_MUL, 32'd100, 32'd3, 32'd300, 1'b1, "b2b_first");
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk("b2b_done_seen", 32'(bus.done), 32'd1);
        issue(F3_MUL, 32'd11, 32'd13, 32'd143, 1'b1, "b2b_second");
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_stall", 32'(bus.stall), 32'd1);
        repeat (3) @(negedge clk);
        issue(F3_MUL, 32'd2, 32'd2, 32'd4, 1'b0, "run_start");
        wait_idle("b2b_second");

        // Reset asserted mid-RUN
        issue(F3_MUL, 32'd5, 32'd5, 32'd25, 1'b0, "reset_mid");
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        @(negedge clk);
        chk("queue_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 Ports SHALL be:
  clk      in   1   clock, all state on rising edge
  rst_n    in   1   asynchronous active-low reset
  start    in   1   request from decode/CU, M-extension multiply issued
  funct3   in   3   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  rs1_val  in   32  operand A
  rs2_val  in   32  operand B
  flush    in   1   pipeline flush, aborts operation
  busy     out  1   operation in progress (RUN or DONE)
  stall    out  1   hold pipeline front end
  done     out  1   one-cycle result-valid pulse
  result   out  32  product half selected by funct3

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-004 IDLE->RUN SHALL occur on an edge with start=1, funct3[2]=0 and flush=0; operands and funct3 are latched on that edge.
REQ-005 A start with funct3[2]=1 SHALL be ignored: no state change, no stall.
REQ-006 Signed operands (A for MULH/MULHSU, B for MULH) SHALL be converted to magnitude at latch; the product sign SHALL be restored after the last iteration.
REQ-007 RUN SHALL perform exactly 32 radix-2 shift-add iterations into a 64-bit accumulator, one per cycle, using a 5-bit counter that wraps 31->0 on the RUN->DONE transition.
REQ-008 DONE SHALL last exactly one cycle. For start accepted at edge T, done=1 during the cycle following edge T+33.
REQ-009 result SHALL be product[31:0] for MUL and product[63:32] otherwise; it is valid only while done=1 and held until the next accepted start.
REQ-010 busy SHALL be 1 in RUN and DONE; stall SHALL be (start & accepted-condition in IDLE) | (state==RUN), combinationally.
REQ-011 start SHALL be accepted in DONE (back-to-back): DONE->RUN directly. In RUN it SHALL be ignored.
REQ-012 flush SHALL force next state IDLE from any state; done SHALL NOT pulse for an aborted operation. flush has priority over start on the same edge.

Reset
REQ-013 On rst_n=0, state SHALL be IDLE asynchronously; busy, stall, done SHALL be 0; result and counter SHALL be 0.
REQ-014 Reset mid-RUN SHALL discard the operation; no done after release.

Configuration
REQ-015 Macro MUL_EARLY_OUT_EN, when defined, SHALL route an accepted start with rs1_val==0 or rs2_val==0 directly to DONE, with result 0 and done in the cycle after edge T+1.
REQ-016 Without MUL_EARLY_OUT_EN, every accepted operation SHALL take the full 33-cycle latency of REQ-008.

Structure
REQ-017 Package mul_pkg SHALL hold the state enum, funct3 op constants, and MUL_ITERS=32.
REQ-018 The shift-add accumulator and sign fix-up SHALL be a sub-module mul_shift_add; mul_ctrl SHALL own the FSM, counter and handshake.

Verification
REQ-019 MUL 7 x 6 -> done in cycle after T+33, result 0x0000002A, stall high through RUN.
REQ-020 MUL and MULH on 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 and 0x00000000; MULHU -> 0xFFFFFFFE.
REQ-021 MULHSU 0xFFFFFFFE x 0x00000003 -> 0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-022 flush at T+10 -> IDLE next edge, no done, busy=0; new start at T+12 completes normally. Simultaneous flush+start -> ignored.
REQ-023 Back-to-back start in DONE accepted; start in RUN ignored; funct3=100 start -> no stall. Reset asserted at T+5 -> outputs 0 immediately, no done.
REQ-024 With MUL_EARLY_OUT_EN: MUL 0 x 5 -> done in cycle after T+1, result 0. Without it: same stimulus -> done after T+33.
